// File: rtl/debug_pkg.sv
// Shared debug-interface definitions: select codes, latch count, serializer states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Select codes are also decoded by the upstream MicroBlaze-MIPS interface, so
// they live here rather than inside the serializer.
package debug_pkg;

  localparam logic [5:0] SEL_MEM_DATA   = 6'h20;
  localparam logic [5:0] SEL_MEM_INSTR  = 6'h21;
  localparam logic [5:0] SEL_PC         = 6'h22;
  localparam logic [5:0] SEL_LATCH_BASE = 6'h24;

  // fetch/deco/exec/mem x data/ctrl
  localparam int N_LATCH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  // Width of a word counter covering n_words entries, never narrower than 1 bit.
  function automatic int idx_width(input int n_words);
    return (n_words > 1) ? $clog2(n_words) : 1;
  endfunction

endpackage

// File: rtl/debug_source_select.sv
// Decodes the debug request select into a zero-extended source word and its last word index.
// Latency: combinational.
// Backpressure: none; outputs follow the inputs every cycle.
//
// Ports:
//   i_request_select           source id
//   i_reg_data/i_pc/i_mem_data/i_instr_data   single-word sources
//   i_latch_bus                N_LATCH strips, strip k at [k*NB_STRIP +: NB_STRIP]
//   o_source                   selected source, NB_STRIP bits, single words zero-extended
//   o_last_idx                 index of the last NB_FRAME word to send (n_words-1)
module debug_source_select
  import debug_pkg::*;
#(
  parameter int NB_FRAME = 32,
  parameter int NB_STRIP = 128,
  parameter int N_LATCH  = debug_pkg::N_LATCH,
  parameter int NB_SEL   = 6,
  parameter int NB_IDX   = 2
) (
  input  logic [NB_SEL-1:0]           i_request_select,
  input  logic [NB_FRAME-1:0]         i_reg_data,
  input  logic [NB_FRAME-1:0]         i_pc,
  input  logic [NB_FRAME-1:0]         i_mem_data,
  input  logic [NB_FRAME-1:0]         i_instr_data,
  input  logic [N_LATCH*NB_STRIP-1:0] i_latch_bus,
  output logic [NB_STRIP-1:0]         o_source,
  output logic [NB_IDX-1:0]           o_last_idx
);

  localparam int N_WORDS = NB_STRIP / NB_FRAME;

  logic [NB_SEL-1:0] latch_off;

  assign latch_off = i_request_select - NB_SEL'(SEL_LATCH_BASE);

  always_comb begin
    o_source   = '0;
    o_last_idx = '0;
    if (i_request_select < NB_SEL'(SEL_MEM_DATA)) begin
      // register file: the address is driven externally from the low select bits
      o_source[NB_FRAME-1:0] = i_reg_data;
    end else if (i_request_select == NB_SEL'(SEL_MEM_DATA)) begin
      o_source[NB_FRAME-1:0] = i_mem_data;
    end else if (i_request_select == NB_SEL'(SEL_MEM_INSTR)) begin
      o_source[NB_FRAME-1:0] = i_instr_data;
    end else if (i_request_select == NB_SEL'(SEL_PC)) begin
      o_source[NB_FRAME-1:0] = i_pc;
    end else if (i_request_select >= NB_SEL'(SEL_LATCH_BASE)) begin
      // Codes past the last strip fall through as invalid: one all-zero word.
      for (int k = 0; k < N_LATCH; k++) begin
        if (latch_off == NB_SEL'(k)) begin
          o_source   = i_latch_bus[k*NB_STRIP +: NB_STRIP];
          o_last_idx = NB_IDX'(N_WORDS - 1);
        end
      end
    end
  end

endmodule

// File: rtl/debug_frame_serializer.sv
// Snapshots the selected MIPS debug source and streams it to the MicroBlaze in NB_FRAME-bit frames.
// Latency: first frame valid 1 cycle after i_read_request; consecutive frames with no bubble.
// Backpressure: each frame is held until i_frame_ack; requests while busy are dropped.
//
// Ports:
//   i_clock, i_reset         clock, synchronous active-high reset
//   i_read_request           one-cycle request strobe, i_request_select sampled with it
//   i_reg_data .. i_latch_bus debug sources
//   i_frame_ack              MicroBlaze consumed the current frame
//   o_frame/o_frame_valid    current frame, least significant word first
//   o_eod                    current frame is the last of the transfer
//   o_busy                   transfer in progress
module debug_frame_serializer
  import debug_pkg::*;
#(
  parameter int NB_FRAME = 32,
  parameter int NB_STRIP = 128,
  parameter int N_LATCH  = debug_pkg::N_LATCH,
  parameter int NB_SEL   = 6
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_read_request,
  input  logic [NB_SEL-1:0]           i_request_select,
  input  logic [NB_FRAME-1:0]         i_reg_data,
  input  logic [NB_FRAME-1:0]         i_pc,
  input  logic [NB_FRAME-1:0]         i_mem_data,
  input  logic [NB_FRAME-1:0]         i_instr_data,
  input  logic [N_LATCH*NB_STRIP-1:0] i_latch_bus,
  input  logic                        i_frame_ack,
  output logic [NB_FRAME-1:0]         o_frame,
  output logic                        o_frame_valid,
  output logic                        o_eod,
  output logic                        o_busy
);

  localparam int N_WORDS = NB_STRIP / NB_FRAME;
  localparam int NB_IDX  = idx_width(N_WORDS);

  ser_state_t            state_q, state_d;
  logic [NB_IDX-1:0]     word_idx_q, word_idx_d;
  logic [NB_IDX-1:0]     last_idx_q, last_idx_d;
  logic [NB_STRIP-1:0]   shadow_q, shadow_d;
  logic [NB_FRAME-1:0]   frame_q, frame_d;
  logic                  valid_q, valid_d;
  logic                  eod_q, eod_d;
  logic                  busy_q, busy_d;

  logic [NB_STRIP-1:0]   src_data;
  logic [NB_IDX-1:0]     src_last_idx;

  debug_source_select #(
    .NB_FRAME (NB_FRAME),
    .NB_STRIP (NB_STRIP),
    .N_LATCH  (N_LATCH),
    .NB_SEL   (NB_SEL),
    .NB_IDX   (NB_IDX)
  ) u_source_select (
    .i_request_select (i_request_select),
    .i_reg_data       (i_reg_data),
    .i_pc             (i_pc),
    .i_mem_data       (i_mem_data),
    .i_instr_data     (i_instr_data),
    .i_latch_bus      (i_latch_bus),
    .o_source         (src_data),
    .o_last_idx       (src_last_idx)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      last_idx_q <= '0;
      shadow_q   <= '0;
      frame_q    <= '0;
      valid_q    <= 1'b0;
      eod_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      last_idx_q <= last_idx_d;
      shadow_q   <= shadow_d;
      frame_q    <= frame_d;
      valid_q    <= valid_d;
      eod_q      <= eod_d;
      busy_q     <= busy_d;
    end
  end

  // Outputs are registered, so every value is computed one cycle ahead: the
  // frame/eod for the word that will be current after this edge.
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    last_idx_d = last_idx_q;
    shadow_d   = shadow_q;
    frame_d    = frame_q;
    valid_d    = valid_q;
    eod_d      = eod_q;
    busy_d     = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (i_read_request) begin
          state_d    = ST_SEND;
          shadow_d   = src_data;
          last_idx_d = src_last_idx;
          word_idx_d = '0;
          frame_d    = src_data[NB_FRAME-1:0];
          eod_d      = (src_last_idx == '0);
          valid_d    = 1'b1;
          busy_d     = 1'b1;
        end
      end

      ST_SEND: begin
        // A request here is ignored, including on the final-ack cycle.
        if (i_frame_ack) begin
          if (word_idx_q == last_idx_q) begin
            state_d    = ST_IDLE;
            word_idx_d = '0;
            frame_d    = '0;
            eod_d      = 1'b0;
            valid_d    = 1'b0;
            busy_d     = 1'b0;
          end else begin
            word_idx_d = word_idx_q + NB_IDX'(1);
            frame_d    = shadow_q[int'(word_idx_d)*NB_FRAME +: NB_FRAME];
            eod_d      = (word_idx_d == last_idx_q);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign o_frame       = frame_q;
  assign o_frame_valid = valid_q;
  assign o_eod         = eod_q;
  assign o_busy        = busy_q;

endmodule

// File: doc/debug_frame_serializer.md
Name: debug_frame_serializer

Overview:
- Consumes the debug read request and 6-bit request select from the MicroBlaze–MIPS debug interface.
- Snapshots the selected MIPS debug source (register, PC, data/instruction memory word, or one pipeline latch strip) into a shadow register.
- Streams the snapshot to the MicroBlaze as NB_FRAME-bit frames under a valid/ack handshake, flagging the last frame with end-of-data (EoD).
- Every latch strip has the fixed width NB_STRIP, the width of the largest strip; narrower strips are zero-padded at the source.

Parameters:
- NB_FRAME, 32, frame width to MicroBlaze; also the width of each single-word source.
- NB_STRIP, 128, latch strip width; must be a multiple of NB_FRAME.
- N_LATCH, 8, number of latch strips (fetch/deco/exec/mem × data/ctrl).
- NB_SEL, 6, request select width.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_read_request  in  1  one-cycle request strobe.
- i_request_select  in  NB_SEL  source id, sampled with i_read_request.
- i_reg_data  in  NB_FRAME  register file debug read port; its address is driven externally from i_request_select[4:0].
- i_pc  in  NB_FRAME  current PC.
- i_mem_data  in  NB_FRAME  data memory debug read word.
- i_instr_data  in  NB_FRAME  instruction memory debug read word.
- i_latch_bus  in  N_LATCH*NB_STRIP  concatenated strips; strip k occupies bits [k*NB_STRIP +: NB_STRIP].
- i_frame_ack  in  1  MicroBlaze consumed the current frame.
- o_frame  out  NB_FRAME  current frame.
- o_frame_valid  out  1  o_frame is valid.
- o_eod  out  1  current frame is the last one of the transfer.
- o_busy  out  1  transfer in progress; new requests are ignored.

Behaviour:
- Select decode:
  - 0x00–0x1F: REG, 1 word, i_reg_data.
  - 0x20: MEM_DATA, 1 word.
  - 0x21: MEM_INSTR, 1 word.
  - 0x22: PC, 1 word.
  - 0x24–0x2B: LATCH k = sel−0x24, NB_STRIP/NB_FRAME words.
  - Any other code: INVALID, 1 word of all zeros.
- State machine with two states, IDLE and SEND.
- IDLE:
  - On i_read_request=1, capture the decoded source into the shadow register (NB_STRIP bits; single-word sources zero-extended).
  - Load n_words; clear word_idx to 0.
  - Go to SEND. Registered outputs update on the same edge, so o_frame_valid=1 in the cycle after the request (latency 1).
- SEND:
  - o_frame = shadow[word_idx*NB_FRAME +: NB_FRAME]; least significant word first.
  - o_frame_valid=1, o_busy=1.
  - o_eod = (word_idx == n_words−1).
- Handshake in SEND:
  - o_frame and o_eod are held stable until a cycle with o_frame_valid & i_frame_ack.
  - On ack of a non-last word: word_idx+1; the next word appears on the following cycle, with no bubble.
  - On ack of the last word: go to IDLE; o_frame_valid, o_eod and o_busy drop the next cycle.
- i_read_request while busy, including the cycle of the final ack, is dropped. No queuing.
- The snapshot is taken only at capture. Changes on the source inputs during SEND do not affect the frames.
- i_frame_ack in IDLE has no effect.
- Counter: word_idx width is $clog2(NB_STRIP/NB_FRAME), minimum 1. It never wraps, because the transfer ends at n_words−1.
- Reset (any state, including mid-transfer): state=IDLE, word_idx=0, shadow=0, o_frame=0, o_frame_valid=0, o_eod=0, o_busy=0. A partial transfer is abandoned without EoD.

Decomposition:
- Package debug_pkg holds:
  - select code constants: SEL_MEM_DATA=6'h20, SEL_MEM_INSTR=6'h21, SEL_PC=6'h22, SEL_LATCH_BASE=6'h24;
  - N_LATCH;
  - the state encoding (IDLE, SEND).
  - The same constants are shared with the upstream interface.
- One combinational sub-module, debug_source_select: decodes the select into the NB_STRIP-bit zero-extended source word plus n_words. The serializer core is the FSM, counter and shadow register.

Test Plan:
- Reg read: select=0x05, i_reg_data=0x1234_5678, ack held at 1 → one frame 0x1234_5678 with o_eod=1, valid 1 cycle after the request; busy clear after ack.
- Latch strip: select=0x26 (strip 2 = 128'h4444…_3333…_2222…_1111…), ack every cycle → frames 0x1111_1111, 0x2222_2222, 0x3333_3333, 0x4444_4444 on consecutive cycles; o_eod only on the 4th.
- Backpressure: the same latch read with ack only every 3rd cycle → each frame held stable until acked; no word skipped or duplicated; the strip input changed mid-transfer has no effect on the frames.
- Invalid/busy: select=0x3F → one zero frame with EoD. A second request during a latch transfer is ignored; the transfer completes normally.
- Reset mid-transfer: reset asserted after the 2nd frame of a latch read → all outputs 0 next cycle, state IDLE. A new PC request (i_pc=0x0000_0040) then returns 0x0000_0040 with EoD.
- Final-ack collision: a new request in the same cycle as the final ack is dropped; a request one cycle later is accepted.
